// File: rtl/object_box_overlay_pkg.sv
// Shared object-pipeline definitions: frame geometry defaults, RGB565 colours,
// coordinate type and the box-update state encoding. The box extractor imports the same package.
package object_box_overlay_pkg;

  localparam int unsigned COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t IMG_HDISP_DEF = 11'd1024;
  localparam coord_t IMG_VDISP_DEF = 11'd768;

  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_E_UP   = 3'd2,
    ST_E_DOWN = 3'd3,
    ST_E_LEFT = 3'd4,
    ST_E_RIGHT = 3'd5
  } upd_state_e;

  // One IIR step: s + ((n - s) >>> sh), 12-bit signed difference, truncated to 11 bits.
  function automatic coord_t iir_step(input coord_t s, input coord_t n, input int unsigned sh);
    logic signed [COORD_W:0] diff;
    logic signed [COORD_W:0] step;
    logic [COORD_W:0]        sum;
    diff = $signed({1'b0, n}) - $signed({1'b0, s});
    step = diff >>> sh;
    sum  = {1'b0, s} + $unsigned(step);
    return sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/object_box_overlay_if.sv
// RGB565 video stream bundle: frame syncs, pixel enable and pixel data.
interface object_box_overlay_if;
  logic        frame_vsync;
  logic        frame_href;
  logic        frame_clken;
  logic [15:0] img_data;

  modport master (output frame_vsync, frame_href, frame_clken, img_data);
  modport slave  (input  frame_vsync, frame_href, frame_clken, img_data);
endinterface

// File: rtl/object_box_overlay_smoother.sv
// Per-frame box update: latch and sanity-check the extractor box, IIR-smooth
// the edges, and hide the box after too many consecutive misses.
module object_box_smoother
  import object_box_overlay_pkg::*;
#(
  parameter coord_t      IMG_HDISP    = IMG_HDISP_DEF,
  parameter coord_t      IMG_VDISP    = IMG_VDISP_DEF,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned MISS_FRAMES  = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   frame_start,
  input  coord_t rect_up,
  input  coord_t rect_down,
  input  coord_t rect_left,
  input  coord_t rect_right,
  input  logic   rect_valid,
  output coord_t box_up,
  output coord_t box_down,
  output coord_t box_left,
  output coord_t box_right,
  output logic   box_on
);

  localparam logic [3:0] MISS = 4'(MISS_FRAMES);

  upd_state_e state;
  coord_t     lat_up, lat_down, lat_left, lat_right;
  logic       lat_ok;
  logic       load_direct;
  logic [3:0] miss_cnt;
  logic       frame_ok;

  always_comb begin
    frame_ok = rect_valid && (rect_up <= rect_down) && (rect_left <= rect_right) &&
               (rect_down < IMG_VDISP) && (rect_right < IMG_HDISP);
  end

  function automatic coord_t next_edge(input coord_t cur, input coord_t nxt, input logic direct);
    return direct ? nxt : iir_step(cur, nxt, SMOOTH_SHIFT);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lat_up      <= '0;
      lat_down    <= '0;
      lat_left    <= '0;
      lat_right   <= '0;
      lat_ok      <= 1'b0;
      load_direct <= 1'b0;
      miss_cnt    <= MISS;
      box_up      <= '0;
      box_down    <= '0;
      box_left    <= '0;
      box_right   <= '0;
      box_on      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (frame_start) state <= ST_LATCH;
        ST_LATCH: begin
          lat_up      <= rect_up;
          lat_down    <= rect_down;
          lat_left    <= rect_left;
          lat_right   <= rect_right;
          lat_ok      <= frame_ok;
          // Hidden-state decision must use the miss count before this frame clears it.
          load_direct <= (miss_cnt >= MISS) || (SMOOTH_SHIFT == 0);
          if (frame_ok)              miss_cnt <= '0;
          else if (miss_cnt != '1)   miss_cnt <= miss_cnt + 4'd1;
          state <= ST_E_UP;
        end
        ST_E_UP: begin
          if (lat_ok) box_up <= next_edge(box_up, lat_up, load_direct);
          state <= ST_E_DOWN;
        end
        ST_E_DOWN: begin
          if (lat_ok) box_down <= next_edge(box_down, lat_down, load_direct);
          state <= ST_E_LEFT;
        end
        ST_E_LEFT: begin
          if (lat_ok) box_left <= next_edge(box_left, lat_left, load_direct);
          state <= ST_E_RIGHT;
        end
        ST_E_RIGHT: begin
          if (lat_ok) box_right <= next_edge(box_right, lat_right, load_direct);
          box_on <= (miss_cnt < MISS);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/object_box_overlay.sv
// Paints the smoothed target bounding box as a coloured border into the
// RGB565 stream with one clock of latency.
module object_box_overlay
  import object_box_overlay_pkg::*;
#(
  parameter coord_t      IMG_HDISP    = IMG_HDISP_DEF,
  parameter coord_t      IMG_VDISP    = IMG_VDISP_DEF,
  parameter int unsigned LINE_W       = 2,
  parameter logic [15:0] BOX_COLOR    = RGB565_RED,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned MISS_FRAMES  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  coord_t                      rect_up,
  input  coord_t                      rect_down,
  input  coord_t                      rect_left,
  input  coord_t                      rect_right,
  input  logic                        rect_valid,
  object_box_overlay_if.slave         per,
  object_box_overlay_if.master        post,
  output logic                        box_on
);

  localparam logic [COORD_W:0] LW = (COORD_W+1)'(LINE_W);

  coord_t x_cnt, y_cnt;
  logic   vs_d1;
  logic   frame_start;
  coord_t box_up, box_down, box_left, box_right;
  logic   hit;

  assign frame_start = per.frame_vsync && !vs_d1;

  object_box_smoother #(
    .IMG_HDISP    (IMG_HDISP),
    .IMG_VDISP    (IMG_VDISP),
    .SMOOTH_SHIFT (SMOOTH_SHIFT),
    .MISS_FRAMES  (MISS_FRAMES)
  ) u_smoother (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .rect_up     (rect_up),
    .rect_down   (rect_down),
    .rect_left   (rect_left),
    .rect_right  (rect_right),
    .rect_valid  (rect_valid),
    .box_up      (box_up),
    .box_down    (box_down),
    .box_left    (box_left),
    .box_right   (box_right),
    .box_on      (box_on)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
      vs_d1 <= 1'b0;
    end else begin
      vs_d1 <= per.frame_vsync;
      if (per.frame_vsync) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (per.frame_clken) begin
        if (x_cnt == IMG_HDISP - 11'd1) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + 11'd1;
        end else begin
          x_cnt <= x_cnt + 11'd1;
        end
      end
    end
  end

  // Compares are widened to 12 bits so edge+LINE_W never wraps on boxes at the frame limit.
  always_comb begin
    logic [COORD_W:0] xe, ye, l, r, u, d;
    xe  = {1'b0, x_cnt};
    ye  = {1'b0, y_cnt};
    l   = {1'b0, box_left};
    r   = {1'b0, box_right};
    u   = {1'b0, box_up};
    d   = {1'b0, box_down};
    hit = box_on && (xe >= l) && (xe <= r) && (ye >= u) && (ye <= d) &&
          ((xe < l + LW) || (xe + LW > r) || (ye < u + LW) || (ye + LW > d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post.frame_vsync <= 1'b0;
      post.frame_href  <= 1'b0;
      post.frame_clken <= 1'b0;
      post.img_data    <= '0;
    end else begin
      post.frame_vsync <= per.frame_vsync;
      post.frame_href  <= per.frame_href;
      post.frame_clken <= per.frame_clken;
      post.img_data    <= (hit && per.frame_clken) ? BOX_COLOR : per.img_data;
    end
  end

endmodule

// File: tb/tb_object_box_overlay.sv
// Directed bench for object_box_overlay on a reduced 48x32 frame: two instances
// (no smoothing / SHIFT=2) share one input stream; output frames are captured and checked.
module tb_object_box_overlay;

  localparam int H = 48;
  localparam int V = 32;
  localparam logic [15:0] BOX = 16'hF800;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [10:0] rect_up = '0, rect_down = '0, rect_left = '0, rect_right = '0;
  logic rect_valid = 1'b0;
  logic box_on_a, box_on_b;

  object_box_overlay_if per_if ();
  object_box_overlay_if post_a_if ();
  object_box_overlay_if post_b_if ();

  always #5 clk = ~clk;

  object_box_overlay #(
    .IMG_HDISP(11'd48), .IMG_VDISP(11'd32), .LINE_W(2), .BOX_COLOR(16'hF800),
    .SMOOTH_SHIFT(0), .MISS_FRAMES(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rect_up(rect_up), .rect_down(rect_down),
    .rect_left(rect_left), .rect_right(rect_right), .rect_valid(rect_valid),
    .per(per_if), .post(post_a_if), .box_on(box_on_a)
  );

  object_box_overlay #(
    .IMG_HDISP(11'd48), .IMG_VDISP(11'd32), .LINE_W(2), .BOX_COLOR(16'hF800),
    .SMOOTH_SHIFT(2), .MISS_FRAMES(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rect_up(rect_up), .rect_down(rect_down),
    .rect_left(rect_left), .rect_right(rect_right), .rect_valid(rect_valid),
    .per(per_if), .post(post_b_if), .box_on(box_on_b)
  );

  typedef struct {
    logic [10:0] up, down, left, right;
    logic        valid;
    logic        busy;
    logic        on_a, on_b;
  } frame_t;

  typedef struct {
    int fr;
    bit on_b;
    int x, y;
    bit hit;
  } pix_t;

  frame_t frames [0:10];
  pix_t   pix [$];

  int checks = 0;
  int failures = 0;

  logic [15:0] img_a [0:H*V-1];
  logic [15:0] img_b [0:H*V-1];
  int cxa = 0, cya = 0, cxb = 0, cyb = 0;

  function automatic logic [15:0] in_pix(input int x, input int y);
    return 16'(32'h1000 + y * H + x);
  endfunction

  always @(negedge clk) begin
    if (post_a_if.frame_vsync) begin
      cxa = 0; cya = 0;
    end else if (post_a_if.frame_clken) begin
      if (cya < V) img_a[cya*H+cxa] = post_a_if.img_data;
      cxa++;
      if (cxa == H) begin cxa = 0; cya++; end
    end
    if (post_b_if.frame_vsync) begin
      cxb = 0; cyb = 0;
    end else if (post_b_if.frame_clken) begin
      if (cyb < V) img_b[cyb*H+cxb] = post_b_if.img_data;
      cxb++;
      if (cxb == H) begin cxb = 0; cyb++; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input logic vs);
    per_if.frame_vsync = vs;
    per_if.frame_href  = 1'b0;
    per_if.frame_clken = 1'b0;
    per_if.img_data    = '0;
  endtask

  // Present the box, pulse vsync (optionally with a second rise while busy), then stream;
  // stops right after driving pixel (stop_x, stop_y) when stop_y >= 0.
  task automatic run_frame(input frame_t f, input int stop_x, input int stop_y);
    logic [8:0] vs_pat;
    rect_up = f.up; rect_down = f.down; rect_left = f.left; rect_right = f.right;
    rect_valid = f.valid;
    vs_pat = f.busy ? 9'b111111011 : 9'b111111111;
    for (int i = 0; i < 9; i++) begin
      drive_idle(vs_pat[i]);
      step();
    end
    drive_idle(1'b0);
    step();
    step();
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        per_if.frame_href  = 1'b1;
        per_if.frame_clken = 1'b1;
        per_if.img_data    = in_pix(x, y);
        step();
        if (stop_y >= 0 && x == stop_x && y == stop_y) return;
      end
    end
    drive_idle(1'b0);
    step();
    step();
  endtask

  initial begin
    frame_t f;
    int nbox;
    logic [15:0] got, exp;

    frames[0]  = '{11'd10, 11'd20, 11'd30, 11'd40, 1'b1, 1'b0, 1'b1, 1'b1};
    frames[1]  = '{11'd25, 11'd20, 11'd30, 11'd40, 1'b1, 1'b0, 1'b1, 1'b1};
    frames[2]  = '{11'd10, 11'd20, 11'd30, 11'd40, 1'b0, 1'b0, 1'b1, 1'b1};
    frames[3]  = '{11'd10, 11'd20, 11'd30, 11'd40, 1'b0, 1'b0, 1'b1, 1'b1};
    frames[4]  = '{11'd10, 11'd20, 11'd30, 11'd40, 1'b0, 1'b0, 1'b0, 1'b0};
    frames[5]  = '{11'd10, 11'd20, 11'd0,  11'd40, 1'b1, 1'b0, 1'b1, 1'b1};
    frames[6]  = '{11'd10, 11'd20, 11'd40, 11'd40, 1'b1, 1'b0, 1'b1, 1'b1};
    frames[7]  = '{11'd10, 11'd20, 11'd40, 11'd40, 1'b1, 1'b0, 1'b1, 1'b1};
    frames[8]  = '{11'd10, 11'd20, 11'd30, 11'd40, 1'b1, 1'b1, 1'b1, 1'b1};
    frames[9]  = '{11'd0,  11'd31, 11'd0,  11'd47, 1'b1, 1'b0, 1'b1, 1'b1};
    frames[10] = '{11'd0,  11'd31, 11'd0,  11'd48, 1'b1, 1'b0, 1'b1, 1'b1};

    // dut_b edges: f0 10/20/30/40 direct, f5 left 0 direct, f6 10, f7 17,
    // f8 20 (single update despite busy rise), f9 7/22/15/41, f10 retained.
    pix.push_back(pix_t'{0, 0, 30, 15, 1}); pix.push_back(pix_t'{0, 0, 32, 15, 0});
    pix.push_back(pix_t'{0, 0, 35, 11, 1}); pix.push_back(pix_t'{0, 0, 35, 12, 0});
    pix.push_back(pix_t'{0, 0, 41, 15, 0}); pix.push_back(pix_t'{0, 0, 40, 15, 1});
    pix.push_back(pix_t'{0, 0, 38, 15, 0}); pix.push_back(pix_t'{0, 0, 30, 20, 1});
    pix.push_back(pix_t'{0, 0, 29, 15, 0}); pix.push_back(pix_t'{0, 1, 30, 15, 1});
    pix.push_back(pix_t'{0, 1, 35, 11, 1});
    pix.push_back(pix_t'{1, 0, 30, 15, 1}); pix.push_back(pix_t'{1, 1, 30, 15, 1});
    pix.push_back(pix_t'{3, 0, 30, 15, 1}); pix.push_back(pix_t'{3, 1, 35, 11, 1});
    pix.push_back(pix_t'{4, 0, 30, 15, 0}); pix.push_back(pix_t'{4, 0, 35, 11, 0});
    pix.push_back(pix_t'{4, 1, 30, 15, 0});
    pix.push_back(pix_t'{5, 0, 0, 15, 1});  pix.push_back(pix_t'{5, 0, 2, 15, 0});
    pix.push_back(pix_t'{5, 1, 0, 15, 1});  pix.push_back(pix_t'{5, 1, 1, 15, 1});
    pix.push_back(pix_t'{5, 1, 2, 15, 0});
    pix.push_back(pix_t'{6, 0, 40, 15, 1}); pix.push_back(pix_t'{6, 0, 41, 15, 0});
    pix.push_back(pix_t'{6, 0, 39, 15, 0}); pix.push_back(pix_t'{6, 0, 40, 10, 1});
    pix.push_back(pix_t'{6, 0, 40, 20, 1}); pix.push_back(pix_t'{6, 0, 40, 21, 0});
    pix.push_back(pix_t'{6, 1, 10, 15, 1}); pix.push_back(pix_t'{6, 1, 9, 15, 0});
    pix.push_back(pix_t'{6, 1, 12, 15, 0});
    pix.push_back(pix_t'{7, 1, 17, 15, 1}); pix.push_back(pix_t'{7, 1, 16, 15, 0});
    pix.push_back(pix_t'{7, 1, 19, 15, 0}); pix.push_back(pix_t'{7, 0, 40, 15, 1});
    pix.push_back(pix_t'{8, 0, 30, 15, 1}); pix.push_back(pix_t'{8, 0, 32, 15, 0});
    pix.push_back(pix_t'{8, 1, 20, 15, 1}); pix.push_back(pix_t'{8, 1, 19, 15, 0});
    pix.push_back(pix_t'{8, 1, 22, 15, 0});
    pix.push_back(pix_t'{9, 0, 0, 0, 1});   pix.push_back(pix_t'{9, 0, 47, 31, 1});
    pix.push_back(pix_t'{9, 0, 2, 2, 0});   pix.push_back(pix_t'{9, 0, 46, 15, 1});
    pix.push_back(pix_t'{9, 0, 45, 15, 0}); pix.push_back(pix_t'{9, 1, 15, 15, 1});
    pix.push_back(pix_t'{9, 1, 17, 15, 0}); pix.push_back(pix_t'{9, 1, 15, 6, 0});
    pix.push_back(pix_t'{10, 0, 0, 0, 1});  pix.push_back(pix_t'{10, 0, 2, 2, 0});
    pix.push_back(pix_t'{10, 1, 15, 15, 1});

    drive_idle(1'b0);
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_post_a", {13'd0, post_a_if.frame_vsync, post_a_if.frame_href,
                         post_a_if.frame_clken, post_a_if.img_data}, 32'd0);
    chk("reset_post_b", {13'd0, post_b_if.frame_vsync, post_b_if.frame_href,
                         post_b_if.frame_clken, post_b_if.img_data}, 32'd0);
    chk("reset_box_on_a", {31'd0, box_on_a}, 32'd0);
    chk("reset_box_on_b", {31'd0, box_on_b}, 32'd0);
    rst_n = 1'b1;
    step();

    // One-clock sync latency.
    per_if.frame_vsync = 1'b1;
    #1;
    chk("latency_vsync_before_edge", {31'd0, post_a_if.frame_vsync}, 32'd0);
    step();
    chk("latency_vsync_after_edge", {31'd0, post_a_if.frame_vsync}, 32'd1);
    drive_idle(1'b0);
    repeat (8) step();

    for (int i = 0; i < 11; i++) begin
      run_frame(frames[i], -1, -1);
      chk($sformatf("f%0d_box_on_a", i), {31'd0, box_on_a}, {31'd0, frames[i].on_a});
      chk($sformatf("f%0d_box_on_b", i), {31'd0, box_on_b}, {31'd0, frames[i].on_b});
      foreach (pix[k]) begin
        if (pix[k].fr == i) begin
          got = pix[k].on_b ? img_b[pix[k].y*H + pix[k].x] : img_a[pix[k].y*H + pix[k].x];
          exp = pix[k].hit ? BOX : in_pix(pix[k].x, pix[k].y);
          chk($sformatf("f%0d_%s_px_%0d_%0d", i, pix[k].on_b ? "b" : "a", pix[k].x, pix[k].y),
              {16'd0, got}, {16'd0, exp});
        end
      end
    end

    // Reset in the middle of a displayed frame.
    f = frames[0];
    run_frame(f, 25, 12);
    chk("midframe_box_on_a_before_reset", {31'd0, box_on_a}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_post_a", {13'd0, post_a_if.frame_vsync, post_a_if.frame_href,
                                  post_a_if.frame_clken, post_a_if.img_data}, 32'd0);
    chk("midframe_reset_post_b", {13'd0, post_b_if.frame_vsync, post_b_if.frame_href,
                                  post_b_if.frame_clken, post_b_if.img_data}, 32'd0);
    chk("midframe_reset_box_on_a", {31'd0, box_on_a}, 32'd0);
    chk("midframe_reset_box_on_b", {31'd0, box_on_b}, 32'd0);
    drive_idle(1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    f.valid = 1'b0;
    run_frame(f, -1, -1);
    chk("post_reset_box_on_a", {31'd0, box_on_a}, 32'd0);
    chk("post_reset_box_on_b", {31'd0, box_on_b}, 32'd0);
    nbox = 0;
    for (int k = 0; k < H*V; k++) if (img_a[k] !== in_pix(k % H, k / H)) nbox++;
    chk("post_reset_frame_a_modified_pixels", nbox, 0);
    nbox = 0;
    for (int k = 0; k < H*V; k++) if (img_b[k] !== in_pix(k % H, k / H)) nbox++;
    chk("post_reset_frame_b_modified_pixels", nbox, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/object_box_overlay.md
# object_box_overlay

Draws the per-frame target bounding box onto the live RGB565 video stream. It sits directly downstream of the object bounding-box extractor and consumes its frame-final up/down/left/right/flag outputs. At each frame start it latches, sanity-checks and optionally IIR-smooths the box, then paints a coloured border of configurable thickness into the pixel stream with one clock of latency.

## Interface
- IMG_HDISP, 11'd1024, active pixels per line
- IMG_VDISP, 11'd768, active lines per frame
- LINE_W, 2, border thickness in pixels (1..8)
- BOX_COLOR, 16'hF800, RGB565 border colour
- SMOOTH_SHIFT, 2, IIR shift; 0 = no smoothing (box taken directly)
- MISS_FRAMES, 4, consecutive invalid frames before the box is hidden (1..15)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- rect_up / rect_down / rect_left / rect_right  in  11 each  box from extractor, stable from last pixel of previous frame
- rect_valid  in  1  extractor flag: target found in previous frame
- per_frame_vsync / per_frame_href / per_frame_clken  in  1 each  input sync
- per_img_data  in  16  input RGB565 pixel
- post_frame_vsync / post_frame_href / post_frame_clken  out  1 each  delayed sync
- post_img_data  out  16  output pixel
- box_on  out  1  box currently displayed

## Operation
- Pixel counters x_cnt/y_cnt (11 bit): cleared while per_frame_vsync high; on clken x increments, wraps to 0 at IMG_HDISP-1 and increments y.
- Frame start = per_frame_vsync rising edge (registered vs_d1 low, vsync high).
- Update FSM: IDLE -> LATCH -> E_UP -> E_DOWN -> E_LEFT -> E_RIGHT -> IDLE, one state per clk.
  - IDLE: wait for frame start.
  - LATCH: sample rect_* and rect_valid. Frame is valid iff rect_valid=1, up<=down, left<=right, down<IMG_VDISP and right<IMG_HDISP.
  - Invalid frame: miss_cnt saturating increment; edge states leave the box untouched.
  - Valid frame: miss_cnt <= 0. If the box was hidden (miss_cnt>=MISS_FRAMES) or SMOOTH_SHIFT=0, each edge state loads its edge directly. Otherwise s <= s + ((new - s) >>> SMOOTH_SHIFT), using a 12-bit signed difference and arithmetic shift; result truncated to 11 bits.
  - A frame start while the FSM is busy is ignored.
- box_on = (miss_cnt < MISS_FRAMES). It is updated only in E_RIGHT, so the box never changes mid-frame.
- Border hit (12-bit compares, no underflow): box_on, and x in [left,right], and y in [up,down], and any of:
  - x < left+LINE_W
  - x+LINE_W > right
  - y < up+LINE_W
  - y+LINE_W > down
- Output: post_img_data = BOX_COLOR on hit with clken, else per_img_data. Syncs pass through.

## Timing
- Latency 1 clk on all post_* signals relative to per_*.
- Reset values: post_* = 0, box_on = 0, smoothed edges = 0, miss_cnt = MISS_FRAMES (hidden), FSM = IDLE, counters = 0.
- Box registers update 6 clk after vsync rises. vsync high must last >= 6 clk, so the update completes in blanking.
- Reset asserted mid-frame: all state clears immediately. The first frame after reset shows no box until a valid update.
- Degenerate box (up=down or left=right): drawn as a LINE_W-thick line or a single row/column, with no wrap.

## Structure
- Shared header object_defs: IMG_HDISP/IMG_VDISP defaults, RGB565 colour constants, 11-bit coordinate width. The extractor uses the same header.
- Sub-module object_box_smoother: holds the FSM, validity check, IIR and miss_cnt; outputs the four edges and box_on.
- Top object_box_overlay: holds the counters, hit logic and output pipeline register.

## Test plan
- Border drawing: SMOOTH_SHIFT=0, box 100/200/300/400 valid. Next frame:
  - (300,150) = F800; (302,150) passes through.
  - (350,101) = F800; (350,102) passes through.
  - (401,150) passes through.
- Smoothing: SHIFT=2, settled left=300, then valid frames with left=340 -> left becomes 310, then 317.
- Loss of target: rect_valid=0 -> box still drawn after 3 invalid frames, hidden after the 4th (box_on=0, stream untouched). A valid frame after that loads edges directly, with no smoothing.
- Geometry check: up=300, down=200, rect_valid=1 -> counted as a miss; the previous box is retained.
- Reset mid-frame at pixel (500,400) -> post_* and box_on go to 0 immediately; the next frame passes through unmodified.
- Frame start while busy: a second vsync rise 3 clk after the first is ignored; edges match a single update.
